// File: rtl/sigma_mem_pkg.sv
// Shared types and constants for the Sigma main-memory unit.
// Holds the controller state enum, bus widths, byte-lane indices and the
// lane-merge helper used for partial-word writes.
package sigma_mem_pkg;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned CNT_W  = 4;

  // Lane 0 is the most significant byte (bits 0:7 in Sigma numbering).
  localparam int unsigned LANE_0 = 0;
  localparam int unsigned LANE_1 = 1;
  localparam int unsigned LANE_2 = 2;
  localparam int unsigned LANE_3 = 3;

  typedef logic [0:WORD_W-1] word_t;
  typedef logic [0:LANES-1]  lane_mask_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam lane_mask_t FULL_LANES = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RMW_READ,
    ST_RMW_WRITE,
    ST_DONE
  } state_t;

  // Replace the enabled lanes of old_w with the matching lanes of new_w.
  function automatic word_t merge_lanes(word_t old_w, word_t new_w, lane_mask_t be);
    word_t r;
    r = old_w;
    if (be[LANE_0]) r[LANE_0*LANE_W +: LANE_W] = new_w[LANE_0*LANE_W +: LANE_W];
    if (be[LANE_1]) r[LANE_1*LANE_W +: LANE_W] = new_w[LANE_1*LANE_W +: LANE_W];
    if (be[LANE_2]) r[LANE_2*LANE_W +: LANE_W] = new_w[LANE_2*LANE_W +: LANE_W];
    if (be[LANE_3]) r[LANE_3*LANE_W +: LANE_W] = new_w[LANE_3*LANE_W +: LANE_W];
    return r;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: combinational read, synchronous full-word write.
// Ports: clock; wr_en/addr/wr_data write port; rd_data reads addr.
// Contents are never reset.
module mem_array
  import sigma_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 16384,
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] addr,
  input  word_t            wr_data,
  output word_t            rd_data
);

  word_t mem [DEPTH_WORDS];

  assign rd_data = mem[addr];

  always_ff @(posedge clock) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/memory_unit.sv
// Main-memory unit for the Sigma CPU: one access at a time over req/ack,
// wait-state timing, byte-lane writes by read-modify-write, and a
// nonexistent-memory fault for addresses at or above DEPTH_WORDS.
// Ports: clock, reset (async high); req/we/byte_en/address/write_data in;
// read_data (held), ack (1-cycle pulse), fault (with ack), busy out.
module memory_unit
  import sigma_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [0:3]    byte_en,
  input  logic [15:31]  address,
  input  logic [0:31]   write_data,
  output logic [0:31]   read_data,
  output logic          ack,
  output logic          fault,
  output logic          busy
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_pend_q, fault_pend_d;
  word_t              read_data_q, read_data_d;
  logic               ack_q, ack_d;
  logic               fault_q, fault_d;
  logic               busy_q, busy_d;

  logic               we_q, we_d;
  lane_mask_t         be_q, be_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  word_t              wdata_q, wdata_d;
  word_t              merge_q, merge_d;

  addr_t              addr_in;
  logic               arr_we;
  word_t              arr_wdata;
  word_t              arr_rdata;

  assign addr_in = address;

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clock   (clock),
    .wr_en   (arr_we),
    .addr    (addr_q),
    .wr_data (arr_wdata),
    .rd_data (arr_rdata)
  );

  // Next-state, array control and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fault_pend_d = fault_pend_q;
    read_data_d  = read_data_q;
    ack_d        = 1'b0;
    fault_d      = 1'b0;
    busy_d       = busy_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    arr_we       = 1'b0;
    arr_wdata    = wdata_q;

    case (state_q)
      ST_IDLE: begin
        // busy stays up through the ack cycle (spent in IDLE) and drops at
        // its closing edge unless a new request is captured there.
        busy_d = 1'b0;
        if (req) begin
          busy_d  = 1'b1;
          we_d    = we;
          be_d    = byte_en;
          addr_d  = addr_in[IDX_W-1:0];
          wdata_d = write_data;
          if (32'(addr_in) >= DEPTH_WORDS) begin
            fault_pend_d = 1'b1;
            state_d      = ST_DONE;
          end else begin
            fault_pend_d = 1'b0;
            cnt_d        = CNT_W'(WAIT_STATES);
            state_d      = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!we_q) begin
          read_data_d = arr_rdata;
          state_d     = ST_DONE;
        end else if (be_q == FULL_LANES) begin
          arr_we  = 1'b1;
          state_d = ST_DONE;
        end else if (be_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RMW_READ;
        end
      end

      ST_RMW_READ: begin
        merge_d = arr_rdata;
        state_d = ST_RMW_WRITE;
      end

      ST_RMW_WRITE: begin
        // The commit cycle also plays the role of DONE, so the merge costs
        // only one cycle over a full-word access.
        arr_we    = 1'b1;
        arr_wdata = merge_lanes(merge_q, wdata_q, be_q);
        ack_d     = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_DONE: begin
        ack_d   = 1'b1;
        fault_d = fault_pend_q;
        if (fault_pend_q && !we_q) read_data_d = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and outputs; reset aborts any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fault_pend_q <= 1'b0;
      read_data_q  <= '0;
      ack_q        <= 1'b0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_pend_q <= fault_pend_d;
      read_data_q  <= read_data_d;
      ack_q        <= ack_d;
      fault_q      <= fault_d;
      busy_q       <= busy_d;
    end
  end

  // Captured request fields and merge word; data path only, not reset.
  always_ff @(posedge clock) begin
    we_q    <= we_d;
    be_q    <= be_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    merge_q <= merge_d;
  end

  assign read_data = read_data_q;
  assign ack       = ack_q;
  assign fault     = fault_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed latency/boundary cases and
// a randomized access stream against a word-level reference model.
module tb_memory_unit;

  localparam int WS    = 2;
  localparam int DEPTH = 16384;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [0:3]  byte_en = 4'b0000;
  logic [16:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ack, fault, busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [int];
  logic [31:0] model_rd = '0;

  memory_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .byte_en    (byte_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ack        (ack),
    .fault      (fault),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access from request to idle; expectations come from the model.
  task automatic do_access(input logic w, input logic [0:3] be, input logic [16:0] a,
                           input logic [31:0] d, input bit poke);
    int          lat, ack_n, acks;
    bit          flt, partial;
    logic [31:0] got_rd, got_fault, m;
    flt     = (int'(a) >= DEPTH);
    partial = w && (be != 4'b0000) && (be != 4'b1111);
    lat     = flt ? 1 : (partial ? WS + 3 : WS + 2);
    if (flt) begin
      if (!w) model_rd = '0;
    end else if (!w) begin
      model_rd = model_mem[int'(a)];
    end else begin
      m = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (be[i]) m = (m & ~(32'hFF00_0000 >> (8 * i))) | (d & (32'hFF00_0000 >> (8 * i)));
      model_mem[int'(a)] = m;
    end

    @(negedge clock);
    req = 1'b1; we = w; byte_en = be; address = a; write_data = d;
    @(posedge clock); #1;
    req = 1'b0; we = 1'($urandom); byte_en = 4'($urandom); write_data = $urandom;
    chk("busy_start", 32'(busy), 1);
    ack_n = -1; acks = 0; got_rd = 32'hDEAD_BEEF; got_fault = 32'hDEAD_BEEF;
    for (int n = 1; n <= lat + 4; n++) begin
      @(posedge clock); #1;
      if (poke) req = (n == 1);
      if (ack) begin
        acks++;
        if (ack_n < 0) begin
          ack_n = n; got_rd = read_data; got_fault = 32'(fault);
        end
      end
      if (n == lat + 1) chk("busy_end", 32'(busy), 0);
    end
    chk("ack_lat", ack_n, lat);
    chk("ack_cnt", acks, 1);
    chk("fault", got_fault, 32'(flt));
    chk("rdata", got_rd, model_rd);
  endtask

  logic [16:0] pool [8] = '{17'h00000, 17'h00001, 17'h00100, 17'h00200,
                            17'h03FFF, 17'h01234, 17'h02AAA, 17'h00FF0};

  initial begin
    int acks, a1, a2;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Preload and read with the nominal latency.
    do_access(1'b1, 4'b1111, 17'h00100, 32'h1234_5678, 1'b0);
    do_access(1'b0, 4'b0000, 17'h00100, 32'h0, 1'b0);

    // Reset while idle clears all outputs.
    @(negedge clock); reset = 1'b1; #1;
    chk("rst_rdata", read_data, 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_busy", 32'(busy), 0);
    model_rd = '0;
    @(negedge clock); reset = 1'b0;

    // Partial write, no-op write, boundary word.
    do_access(1'b1, 4'b1111, 17'h00200, 32'hAABB_CCDD, 1'b0);
    do_access(1'b1, 4'b0101, 17'h00200, 32'h1122_3344, 1'b0);
    do_access(1'b0, 4'b0000, 17'h00200, 32'h0, 1'b0);
    chk("merge_val", model_rd, 32'hAA22_CC44);
    do_access(1'b1, 4'b0000, 17'h00200, 32'hFFFF_FFFF, 1'b0);
    do_access(1'b0, 4'b0000, 17'h00200, 32'h0, 1'b0);
    do_access(1'b1, 4'b1111, 17'h03FFF, 32'hCAFE_F00D, 1'b0);
    do_access(1'b0, 4'b0000, 17'h03FFF, 32'h0, 1'b0);

    // Faults: first out-of-range word (aliases word 0 if not gated) and top.
    do_access(1'b1, 4'b1111, 17'h00000, 32'h5A5A_0001, 1'b0);
    do_access(1'b0, 4'b0000, 17'h00100, 32'h0, 1'b0);
    do_access(1'b0, 4'b0000, 17'h04000, 32'h0, 1'b0);
    do_access(1'b0, 4'b0000, 17'h1FFFF, 32'h0, 1'b0);
    do_access(1'b0, 4'b0000, 17'h00000, 32'h0, 1'b0);

    // Reset during RMW_READ: no ack, word unchanged.
    @(negedge clock);
    req = 1'b1; we = 1'b1; byte_en = 4'b1000; address = 17'h00200; write_data = 32'h9900_0000;
    @(posedge clock); #1; req = 1'b0;
    repeat (3) @(posedge clock);
    #2; reset = 1'b1; #1;
    chk("rstmid_ack", 32'(ack), 0);
    chk("rstmid_busy", 32'(busy), 0);
    model_rd = '0;
    @(negedge clock); reset = 1'b0;
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clock); #1;
      if (ack) acks++;
    end
    chk("rstmid_noack", acks, 0);
    do_access(1'b0, 4'b0000, 17'h00200, 32'h0, 1'b0);

    // req toggled while busy is ignored.
    do_access(1'b0, 4'b0000, 17'h00100, 32'h0, 1'b1);

    // req held through ack is re-accepted at the ack-ending edge.
    @(negedge clock);
    req = 1'b1; we = 1'b0; byte_en = 4'b0000; address = 17'h00100;
    @(posedge clock); #1;
    acks = 0; a1 = -1; a2 = -1;
    for (int n = 1; n <= 2 * (WS + 2) + 5; n++) begin
      @(posedge clock); #1;
      if (n == WS + 3) req = 1'b0;
      if (ack) begin
        acks++;
        if (a1 < 0) a1 = n; else if (a2 < 0) a2 = n;
      end
    end
    chk("hold_acks", acks, 2);
    chk("hold_ack1", a1, WS + 2);
    chk("hold_ack2", a2, 2 * (WS + 2) + 1);
    chk("hold_rdata", read_data, model_mem[32'h100]);

    // Randomized stream over a small address pool plus out-of-range reads.
    foreach (pool[i]) do_access(1'b1, 4'b1111, pool[i], $urandom, 1'b0);
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0)
        do_access(1'b0, 4'b0000, 17'($urandom_range(DEPTH, 17'h1FFFF)), 32'h0, 1'b0);
      else
        do_access(1'($urandom), 4'($urandom), pool[$urandom_range(0, 7)], $urandom,
                  $urandom_range(0, 3) == 0);
    end
    foreach (pool[i]) do_access(1'b0, 4'b0000, pool[i], 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
